// File: rtl/rect_ctl_pkg.sv
// Shared definitions for the rectangle fall controller: FSM state encoding,
// default position width and a small unsigned min() helper.
package rect_ctl_pkg;

  localparam int POS_W_DEF = 12;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_FALLING = 2'd1,
    ST_LANDED  = 2'd2,
    ST_RISING  = 2'd3
  } state_e;

  function automatic int unsigned min_u(input int unsigned a, input int unsigned b);
    return (a < b) ? a : b;
  endfunction

endpackage

// File: rtl/rect_fall_ctl_tick_gen.sv
// Motion-tick prescaler: one-cycle tick every TICK_DIV clocks, restartable via clr.
module tick_gen #(
  parameter int TICK_DIV = 100000
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  output logic tick
);

  localparam int CNT_W = $clog2(TICK_DIV);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TICK_DIV - 1);

  logic [CNT_W-1:0] cnt;

  assign tick = (cnt == CNT_LAST);

  // NOTE: sequential state is updated with non-blocking assignments only, so
  // every register samples the pre-edge value of every other register.
  always_ff @(posedge clk) begin
    if (!rst || clr) cnt <= '0;
    else if (tick)   cnt <= '0;
    else             cnt <= cnt + 1'b1;
  end

endmodule

// File: rtl/rect_fall_ctl.sv
// Rectangle fall controller: tracks the object in IDLE, drops the rectangle on a
// start-button edge with gravity and a velocity clamp, then holds on the floor.
// Optional bounce behaviour is enabled by defining RECT_BOUNCE_EN.
module rect_fall_ctl
  import rect_ctl_pkg::*;
#(
  parameter int POS_W      = POS_W_DEF,
  parameter int VEL_W      = 6,
  parameter int TICK_DIV   = 100000,
  parameter int GRAVITY    = 1,
  parameter int VMAX       = 16,
  parameter int FLOOR_Y    = 580,
  parameter int HOLD_TICKS = 50
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             space_button,
  input  logic             abort,
  input  logic [POS_W-1:0] obj_xpos,
  input  logic [POS_W-1:0] obj_ypos,
  output logic [POS_W-1:0] xpos,
  output logic [POS_W-1:0] ypos,
  output logic             busy,
  output logic             landed
);

  localparam int HOLD_W = $clog2(HOLD_TICKS + 1);
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(HOLD_TICKS - 1);

  state_e            state_q, state_d;
  logic              btn_q, start, tick, clr;
  logic [VEL_W-1:0]  vel_q, vel_d, v_new;
  logic [HOLD_W-1:0] hold_q, hold_d;
  logic [POS_W-1:0]  xpos_d, ypos_d;
  logic              landed_d;
  logic [31:0]       vel_sum;
  logic [POS_W:0]    y_sum;

  tick_gen #(.TICK_DIV(TICK_DIV)) u_tick (
    .clk  (clk),
    .rst  (rst),
    .clr  (clr),
    .tick (tick)
  );

  assign start = space_button & ~btn_q;

  // Falling step computed one bit wider than the position so a floor
  // crossing near the top of the range cannot wrap.
  assign vel_sum = 32'(vel_q) + 32'(GRAVITY);
  assign v_new   = VEL_W'(min_u(vel_sum, 32'(VMAX)));
  assign y_sum   = {1'b0, ypos} + (POS_W + 1)'(v_new);

`ifdef RECT_BOUNCE_EN
  logic [POS_W-1:0] y_up;
  logic [VEL_W-1:0] vel_dec;
  assign y_up    = (ypos < POS_W'(vel_q)) ? '0 : ypos - POS_W'(vel_q);
  assign vel_dec = (vel_q > VEL_W'(GRAVITY)) ? vel_q - VEL_W'(GRAVITY) : '0;
`endif

  // NOTE: every signal driven here gets a default first, so no path can
  // leave one unassigned and infer a latch.
  always_comb begin
    state_d  = state_q;
    xpos_d   = xpos;
    ypos_d   = ypos;
    vel_d    = vel_q;
    hold_d   = hold_q;
    landed_d = 1'b0;
    clr      = 1'b0;
    case (state_q)
      ST_IDLE: begin
        xpos_d = obj_xpos;
        ypos_d = obj_ypos;
        if (abort) begin
          clr = 1'b1;
        end else if (start) begin
          state_d = ST_FALLING;
          vel_d   = '0;
          clr     = 1'b1;
        end
      end
      ST_FALLING: begin
        if (abort) begin
          state_d = ST_IDLE;
          clr     = 1'b1;
        end else if (tick) begin
          vel_d = v_new;
          if (y_sum >= (POS_W + 1)'(FLOOR_Y)) begin
            ypos_d   = POS_W'(FLOOR_Y);
            landed_d = 1'b1;
`ifdef RECT_BOUNCE_EN
            if (v_new > VEL_W'(2)) begin
              vel_d   = v_new >> 1;
              state_d = ST_RISING;
            end else begin
              state_d = ST_LANDED;
              hold_d  = '0;
            end
`else
            state_d = ST_LANDED;
            hold_d  = '0;
`endif
          end else begin
            ypos_d = y_sum[POS_W-1:0];
          end
        end
      end
      ST_LANDED: begin
        if (abort) begin
          state_d = ST_IDLE;
          clr     = 1'b1;
        end else if (tick) begin
          if (hold_q == HOLD_LAST) state_d = ST_IDLE;
          else                     hold_d  = hold_q + 1'b1;
        end
      end
      ST_RISING: begin
`ifdef RECT_BOUNCE_EN
        if (abort) begin
          state_d = ST_IDLE;
          clr     = 1'b1;
        end else if (tick) begin
          ypos_d = y_up;
          vel_d  = vel_dec;
          if (vel_dec == '0) state_d = ST_FALLING;
        end
`else
        state_d = ST_IDLE;
`endif
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= ST_IDLE;
      btn_q   <= 1'b0;
      xpos    <= '0;
      ypos    <= '0;
      vel_q   <= '0;
      hold_q  <= '0;
      busy    <= 1'b0;
      landed  <= 1'b0;
    end else begin
      state_q <= state_d;
      btn_q   <= space_button;
      xpos    <= xpos_d;
      ypos    <= ypos_d;
      vel_q   <= vel_d;
      hold_q  <= hold_d;
      busy    <= (state_d != ST_IDLE);
      landed  <= landed_d;
    end
  end

endmodule

// File: tb/tb_rect_fall_ctl.sv
// Self-checking bench for rect_fall_ctl: directed vector table, multi-cycle
// fall sequences and a randomized run against a behavioural reference model.
module tb_rect_fall_ctl;

  localparam int POS_W      = 12;
  localparam int VEL_W      = 6;
  localparam int TICK_DIV   = 4;
  localparam int GRAVITY    = 1;
  localparam int VMAX       = 3;
  localparam int FLOOR_Y    = 20;
  localparam int HOLD_TICKS = 2;
`ifdef RECT_BOUNCE_EN
  localparam bit BOUNCE = 1'b1;
`else
  localparam bit BOUNCE = 1'b0;
`endif
  localparam int EXP_LANDS = BOUNCE ? 2 : 1;

  logic             clk = 1'b0;
  logic             rst, space_button, abort;
  logic [POS_W-1:0] obj_xpos, obj_ypos, xpos, ypos;
  logic             busy, landed;

  int checks = 0;
  int failures = 0;

  rect_fall_ctl #(
    .POS_W(POS_W), .VEL_W(VEL_W), .TICK_DIV(TICK_DIV), .GRAVITY(GRAVITY),
    .VMAX(VMAX), .FLOOR_Y(FLOOR_Y), .HOLD_TICKS(HOLD_TICKS)
  ) dut (
    .clk(clk), .rst(rst), .space_button(space_button), .abort(abort),
    .obj_xpos(obj_xpos), .obj_ypos(obj_ypos),
    .xpos(xpos), .ypos(ypos), .busy(busy), .landed(landed)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Reference model: mode 0 tracking, 1 dropping, 2 resting, 3 rebounding.
  int m_mode, m_x, m_y, m_vel, m_cnt, m_hold;
  bit m_btn, m_busy, m_landed;

  task automatic model_step(input bit r, input bit b, input bit a, input int ox, input int oy);
    bit start, tick, clr;
    int v, y;
    m_landed = 1'b0;
    clr = 1'b0;
    if (!r) begin
      m_mode = 0; m_x = 0; m_y = 0; m_vel = 0; m_cnt = 0; m_hold = 0;
      m_btn = 1'b0; m_busy = 1'b0;
      return;
    end
    start = b && !m_btn;
    m_btn = b;
    tick  = (m_cnt == TICK_DIV - 1);
    if (m_mode == 0) begin
      m_x = ox;
      m_y = oy;
      if (a) clr = 1'b1;
      else if (start) begin
        m_mode = 1; m_vel = 0; clr = 1'b1;
      end
    end else if (a) begin
      m_mode = 0;
      clr = 1'b1;
    end else if (tick) begin
      case (m_mode)
        1: begin
          v = m_vel + GRAVITY;
          if (v > VMAX) v = VMAX;
          y = m_y + v;
          if (y >= FLOOR_Y) begin
            m_y = FLOOR_Y;
            m_landed = 1'b1;
            if (BOUNCE && v > 2) begin
              m_vel = v / 2; m_mode = 3;
            end else begin
              m_mode = 2; m_hold = 0;
            end
          end else begin
            m_y = y; m_vel = v;
          end
        end
        2: begin
          m_hold++;
          if (m_hold >= HOLD_TICKS) m_mode = 0;
        end
        3: begin
          y = m_y - m_vel;
          m_y = (y < 0) ? 0 : y;
          m_vel = (m_vel > GRAVITY) ? m_vel - GRAVITY : 0;
          if (m_vel == 0) m_mode = 1;
        end
        default: m_mode = 0;
      endcase
    end
    m_cnt = clr ? 0 : (m_cnt + 1) % TICK_DIV;
    m_busy = (m_mode != 0);
  endtask

  // Follows an in-progress fall until busy drops, recording the ypos values seen.
  task automatic watch_fall(input int exp_seq[$], input string tag);
    int seen[$];
    int lcount = 0;
    int n = 0;
    int last_y = int'(ypos);
    int since_land = -1;
    while (busy && n < 400) begin
      step();
      n++;
      if (landed) begin
        lcount++;
        since_land = 0;
      end else if (since_land >= 0) begin
        since_land++;
      end
      if (busy && int'(ypos) != last_y) begin
        seen.push_back(int'(ypos));
        last_y = int'(ypos);
      end
    end
    check({tag, " finished"}, 32'(n < 400), 32'd1);
    check({tag, " landed pulses"}, lcount, EXP_LANDS);
    check({tag, " hold cycles"}, since_land, HOLD_TICKS * TICK_DIV);
    check({tag, " ypos count"}, seen.size(), exp_seq.size());
    for (int i = 0; i < exp_seq.size(); i++)
      check($sformatf("%s ypos[%0d]", tag, i), (i < seen.size()) ? seen[i] : -1, exp_seq[i]);
  endtask

  typedef struct {
    bit rst, btn, abort;
    int ox, oy;
    int ex, ey;
    bit eb, el;
  } vec_t;

  vec_t tbl[7];

  initial begin
    int q[$];
    int n, rises, lands;
    bit prev_busy;

    rst = 1'b0; space_button = 1'b0; abort = 1'b0;
    obj_xpos = 12'd100; obj_ypos = 12'd5;

    // Reset, IDLE tracking, start+abort collision, then a real start.
    tbl[0] = '{1'b0, 1'b0, 1'b0, 100, 5,   0,  0, 1'b0, 1'b0};
    tbl[1] = '{1'b0, 1'b0, 1'b0, 100, 5,   0,  0, 1'b0, 1'b0};
    tbl[2] = '{1'b1, 1'b0, 1'b0, 100, 5, 100,  5, 1'b0, 1'b0};
    tbl[3] = '{1'b1, 1'b0, 1'b0,   7, 30,  7, 30, 1'b0, 1'b0};
    tbl[4] = '{1'b1, 1'b1, 1'b1, 100, 5, 100,  5, 1'b0, 1'b0};
    tbl[5] = '{1'b1, 1'b0, 1'b0, 100, 5, 100,  5, 1'b0, 1'b0};
    tbl[6] = '{1'b1, 1'b1, 1'b0, 100, 5, 100,  5, 1'b1, 1'b0};
    for (int i = 0; i < 7; i++) begin
      rst = tbl[i].rst; space_button = tbl[i].btn; abort = tbl[i].abort;
      obj_xpos = POS_W'(tbl[i].ox); obj_ypos = POS_W'(tbl[i].oy);
      step();
      check($sformatf("vec%0d xpos", i), xpos, tbl[i].ex);
      check($sformatf("vec%0d ypos", i), ypos, tbl[i].ey);
      check($sformatf("vec%0d busy", i), busy, tbl[i].eb);
      check($sformatf("vec%0d landed", i), landed, tbl[i].el);
    end

    // Fall from y=5 with the object moving away; expect the gravity profile.
    obj_xpos = 12'd50; obj_ypos = 12'd50;
    if (BOUNCE) q = '{6, 8, 11, 14, 17, 20, 19, 20};
    else        q = '{6, 8, 11, 14, 17, 20};
    watch_fall(q, "fall");
    step();
    check("fall retrack x", xpos, 50);
    check("fall retrack y", ypos, 50);

    // Start already below the floor: clamps on the first tick.
    space_button = 1'b0; obj_xpos = 12'd60; obj_ypos = 12'd25;
    step();
    space_button = 1'b1;
    step();
    n = 0;
    while (!landed && n < 20) begin
      step();
      n++;
    end
    check("deep land latency", n, TICK_DIV);
    check("deep land ypos", ypos, FLOOR_Y);
    check("deep land xpos", xpos, 60);
    n = 0;
    while (busy && n < 50) begin
      step();
      n++;
      if (busy && ypos != 12'(FLOOR_Y)) check("deep hold ypos", ypos, FLOOR_Y);
    end
    check("deep idle", busy, 0);

    // Abort mid-fall at ypos=11.
    space_button = 1'b0; obj_xpos = 12'd100; obj_ypos = 12'd5;
    step();
    space_button = 1'b1;
    step();
    n = 0;
    while (ypos != 12'd11 && n < 100) begin
      step();
      n++;
    end
    check("abort reach 11", ypos, 11);
    abort = 1'b1; obj_xpos = 12'd33; obj_ypos = 12'd44;
    step();
    abort = 1'b0;
    check("abort busy", busy, 0);
    check("abort landed", landed, 0);
    step();
    check("abort track x", xpos, 33);
    check("abort track y", ypos, 44);
    lands = 0; rises = 0;
    for (int i = 0; i < 30; i++) begin
      step();
      lands += int'(landed);
      rises += int'(busy);
    end
    check("abort no land", lands, 0);
    check("abort no restart", rises, 0);

    // Button held for 100 cycles: exactly one fall.
    space_button = 1'b0; obj_xpos = 12'd100; obj_ypos = 12'd5;
    step();
    space_button = 1'b1;
    rises = 0; lands = 0; prev_busy = busy;
    for (int i = 0; i < 100; i++) begin
      step();
      if (busy && !prev_busy) rises++;
      prev_busy = busy;
      lands += int'(landed);
    end
    check("held falls", rises, 1);
    check("held lands", lands, EXP_LANDS);
    check("held idle", busy, 0);

    // New edge starts a second fall; presses while busy are not queued.
    space_button = 1'b0;
    step();
    space_button = 1'b1;
    step();
    check("second fall busy", busy, 1);
    n = 0; rises = 0; prev_busy = 1'b1;
    while (busy && n < 200) begin
      space_button = n[1];
      step();
      n++;
    end
    space_button = 1'b0;
    check("second fall ends", 32'(n < 200), 32'd1);
    for (int i = 0; i < 5; i++) begin
      step();
      rises += int'(busy);
    end
    check("no queued start", rises, 0);

`ifdef RECT_BOUNCE_EN
    // Bounce: contact at v'=3 rebounds one pixel, then reset mid-bounce.
    obj_xpos = 12'd100; obj_ypos = 12'd5;
    step();
    space_button = 1'b1;
    step();
    n = 0;
    while (!landed && n < 200) begin
      step();
      n++;
    end
    check("bounce contact", ypos, FLOOR_Y);
    n = 0;
    while (ypos == 12'(FLOOR_Y) && n < 50) begin
      step();
      n++;
    end
    check("bounce rise ypos", ypos, 19);
    check("bounce rise busy", busy, 1);
    n = 0;
    while (busy && n < 200) begin
      step();
      n++;
    end
    space_button = 1'b0;
    step();
    space_button = 1'b1;
    step();
    n = 0;
    while (!landed && n < 200) begin
      step();
      n++;
    end
    check("bounce2 contact", landed, 1);
    rst = 1'b0; space_button = 1'b0;
    step();
    check("bounce rst xpos", xpos, 0);
    check("bounce rst ypos", ypos, 0);
    check("bounce rst busy", busy, 0);
    check("bounce rst landed", landed, 0);
    rst = 1'b1;
`endif

    // Randomized run against the reference model.
    rst = 1'b0; space_button = 1'b0; abort = 1'b0;
    for (int i = 0; i < 2; i++) begin
      model_step(rst, space_button, abort, int'(obj_xpos), int'(obj_ypos));
      step();
    end
    for (int i = 0; i < 3000; i++) begin
      rst = ($urandom_range(0, 299) != 0);
      if ($urandom_range(0, 3) == 0) space_button = ~space_button;
      abort = ($urandom_range(0, 63) == 0);
      if ($urandom_range(0, 7) == 0) begin
        obj_xpos = POS_W'($urandom_range(0, 4095));
        obj_ypos = POS_W'($urandom_range(0, 30));
      end
      model_step(rst, space_button, abort, int'(obj_xpos), int'(obj_ypos));
      step();
      check($sformatf("rnd%0d xpos", i), xpos, m_x);
      check($sformatf("rnd%0d ypos", i), ypos, m_y);
      check($sformatf("rnd%0d busy", i), busy, m_busy);
      check($sformatf("rnd%0d landed", i), landed, m_landed);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
